// File: rtl/store_fence_ctrl_pkg.sv
// Shared types for the store/fence sequencer: fence kinds and controller states.
package store_fence_ctrl_pkg;

  typedef enum logic [1:0] {
    FENCE_DATA  = 2'd0,
    FENCE_INSTR = 2'd1,
    FENCE_VMA   = 2'd2,
    FENCE_RSVD  = 2'd3
  } fence_kind_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    FLUSH_DC = 2'd2,
    DONE     = 2'd3
  } fence_state_e;

endpackage

// File: rtl/store_fence_ctrl_store_cnt.sv
// Saturating up/down counter of in-flight stores with a sticky underflow flag.
module store_cnt #(
  parameter int unsigned MaxCount = 7,
  parameter int unsigned CntWidth = $clog2(MaxCount + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                zero_o,
  output logic                full_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] MaxVal = CntWidth'(MaxCount);

  logic [CntWidth-1:0] cnt_d, cnt_q;
  logic                err_d, err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != MaxVal) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      // An ack with nothing in flight is a protocol error; hold at zero.
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign full_o = (cnt_q >= MaxVal);
  assign err_o  = err_q;

endmodule

// File: rtl/store_fence_ctrl.sv
// Store issue throttling and fence sequencing (drain, optional dcache flush, flush pulses).
module store_fence_ctrl
  import store_fence_ctrl_pkg::*;
#(
  parameter int unsigned MaxOutstandingStores = 7,
  parameter bit          FlushOnFence         = 1'b0,
  parameter int unsigned CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                store_issue_valid_i,
  output logic                store_issue_ready_o,
  input  logic                store_ack_i,
  input  logic                fence_valid_i,
  input  logic [1:0]          fence_kind_i,
  output logic                fence_ready_o,
  output logic                fence_done_o,
  output logic                dcache_flush_o,
  input  logic                dcache_flush_ack_i,
  output logic                icache_flush_o,
  output logic                tlb_flush_o,
  output logic [CntWidth-1:0] outstanding_cnt_o,
  output logic                no_st_pending_o,
  output logic                cnt_err_o
);

  fence_state_e state_d, state_q;
  fence_kind_t  kind_d, kind_q;
  logic         cnt_full;
  logic         cnt_zero;
  logic         store_accept;

  // A pending fence blocks stores in the same cycle so the drain sees a stable set.
  assign store_issue_ready_o = (state_q == IDLE) && !fence_valid_i && !cnt_full;
  assign fence_ready_o       = (state_q == IDLE);
  assign store_accept        = store_issue_valid_i && store_issue_ready_o;
  assign no_st_pending_o     = cnt_zero;

  store_cnt #(
    .MaxCount (MaxOutstandingStores),
    .CntWidth (CntWidth)
  ) u_store_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (store_accept),
    .dec_i  (store_ack_i),
    .cnt_o  (outstanding_cnt_o),
    .zero_o (cnt_zero),
    .full_o (cnt_full),
    .err_o  (cnt_err_o)
  );

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    dcache_flush_o = 1'b0;
    fence_done_o   = 1'b0;
    icache_flush_o = 1'b0;
    tlb_flush_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fence_valid_i) begin
          kind_d  = fence_kind_t'(fence_kind_i);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Abort wins over a same-cycle drain completion.
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = FlushOnFence ? FLUSH_DC : DONE;
        end
      end
      FLUSH_DC: begin
        dcache_flush_o = 1'b1;
        if (dcache_flush_ack_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        fence_done_o   = 1'b1;
        icache_flush_o = (kind_q == FENCE_INSTR);
        tlb_flush_o    = (kind_q == FENCE_VMA);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      kind_q  <= FENCE_DATA;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

endmodule

// File: tb/tb_store_fence_ctrl.sv
// Bench for store_fence_ctrl: two instances (no dcache flush / flush on fence) vs a behavioural model.
module tb_store_fence_ctrl;

  localparam int unsigned Max = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       flush, st_valid, st_ack, f_valid, dc_ack;
  logic [1:0] f_kind;

  logic       st_rdy [2];
  logic       f_rdy  [2];
  logic       done   [2];
  logic       dc     [2];
  logic       ic     [2];
  logic       tlb    [2];
  logic [2:0] cnt    [2];
  logic       nsp    [2];
  logic       err    [2];

  int total = 0;
  int bad   = 0;

  // Model state: in-flight count, error flag, and a fence record per instance.
  int m_cnt    [2];
  bit m_err    [2];
  bit f_busy   [2];
  bit f_dcw    [2];
  bit f_fin    [2];
  int f_kind_m [2];

  store_fence_ctrl #(
    .MaxOutstandingStores (Max),
    .FlushOnFence         (1'b0)
  ) u_dut0 (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .store_issue_valid_i (st_valid),
    .store_issue_ready_o (st_rdy[0]),
    .store_ack_i         (st_ack),
    .fence_valid_i       (f_valid),
    .fence_kind_i        (f_kind),
    .fence_ready_o       (f_rdy[0]),
    .fence_done_o        (done[0]),
    .dcache_flush_o      (dc[0]),
    .dcache_flush_ack_i  (dc_ack),
    .icache_flush_o      (ic[0]),
    .tlb_flush_o         (tlb[0]),
    .outstanding_cnt_o   (cnt[0]),
    .no_st_pending_o     (nsp[0]),
    .cnt_err_o           (err[0])
  );

  store_fence_ctrl #(
    .MaxOutstandingStores (Max),
    .FlushOnFence         (1'b1)
  ) u_dut1 (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .store_issue_valid_i (st_valid),
    .store_issue_ready_o (st_rdy[1]),
    .store_ack_i         (st_ack),
    .fence_valid_i       (f_valid),
    .fence_kind_i        (f_kind),
    .fence_ready_o       (f_rdy[1]),
    .fence_done_o        (done[1]),
    .dcache_flush_o      (dc[1]),
    .dcache_flush_ack_i  (dc_ack),
    .icache_flush_o      (ic[1]),
    .tlb_flush_o         (tlb[1]),
    .outstanding_cnt_o   (cnt[1]),
    .no_st_pending_o     (nsp[1]),
    .cnt_err_o           (err[1])
  );

  task automatic chk(input string name, input int inst, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, inst, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]    = 0;
      m_err[i]    = 1'b0;
      f_busy[i]   = 1'b0;
      f_dcw[i]    = 1'b0;
      f_fin[i]    = 1'b0;
      f_kind_m[i] = 0;
    end
  endtask

  function automatic bit model_st_rdy(input int i);
    return !f_busy[i] && !f_valid && (m_cnt[i] < int'(Max));
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("m_st_rdy", i, int'(st_rdy[i]), int'(model_st_rdy(i)));
      chk("m_f_rdy",  i, int'(f_rdy[i]),  int'(!f_busy[i]));
      chk("m_done",   i, int'(done[i]),   int'(f_fin[i]));
      chk("m_icache", i, int'(ic[i]),     int'(f_fin[i] && f_kind_m[i] == 1));
      chk("m_tlb",    i, int'(tlb[i]),    int'(f_fin[i] && f_kind_m[i] == 2));
      chk("m_dcache", i, int'(dc[i]),     int'(f_dcw[i]));
      chk("m_cnt",    i, int'(cnt[i]),    m_cnt[i]);
      chk("m_nsp",    i, int'(nsp[i]),    int'(m_cnt[i] == 0));
      chk("m_err",    i, int'(err[i]),    int'(m_err[i]));
    end
  endtask

  // Advance the model by one clock using the inputs held through the coming edge.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit acc;
      bit drained;
      acc     = model_st_rdy(i) && st_valid;
      drained = (m_cnt[i] == 0);
      if (acc && !st_ack) begin
        m_cnt[i]++;
      end else if (st_ack && !acc) begin
        if (m_cnt[i] == 0) m_err[i] = 1'b1;
        else m_cnt[i]--;
      end
      if (f_fin[i]) begin
        f_fin[i]  = 1'b0;
        f_busy[i] = 1'b0;
      end else if (f_dcw[i]) begin
        if (dc_ack) begin
          f_dcw[i] = 1'b0;
          f_fin[i] = 1'b1;
        end
      end else if (f_busy[i]) begin
        if (flush) begin
          f_busy[i] = 1'b0;
        end else if (drained) begin
          if (i == 1) f_dcw[i] = 1'b1;
          else f_fin[i] = 1'b1;
        end
      end else if (f_valid) begin
        f_busy[i]   = 1'b1;
        f_kind_m[i] = int'(f_kind);
      end
    end
  endtask

  // Inputs are driven at posedge+1; compare at posedge+3, then step the model and cross the edge.
  task automatic cyc();
    #2;
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush    = 1'b0;
    st_valid = 1'b0;
    st_ack   = 1'b0;
    f_valid  = 1'b0;
    f_kind   = 2'd0;
    dc_ack   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_st_rdy"}, i, int'(st_rdy[i]), 1);
      chk({tag, "_f_rdy"},  i, int'(f_rdy[i]),  1);
      chk({tag, "_nsp"},    i, int'(nsp[i]),    1);
      chk({tag, "_cnt"},    i, int'(cnt[i]),    0);
      chk({tag, "_err"},    i, int'(err[i]),    0);
      chk({tag, "_done"},   i, int'(done[i]),   0);
      chk({tag, "_dc"},     i, int'(dc[i]),     0);
      chk({tag, "_ic"},     i, int'(ic[i]),     0);
      chk({tag, "_tlb"},    i, int'(tlb[i]),    0);
    end
  endtask

  initial begin
    idle_in();
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Fill to the limit with back-to-back stores.
    st_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fill_rdy", 0, int'(st_rdy[0]), (k < 7) ? 1 : 0);
      chk("fill_cnt", 0, int'(cnt[0]), k);
      cyc();
    end
    st_valid = 1'b0;
    st_ack   = 1'b1;
    #1 chk("full_cnt", 0, int'(cnt[0]), 7);
    cyc();
    st_ack = 1'b0;
    #1;
    chk("after_ack_rdy", 0, int'(st_rdy[0]), 1);
    chk("after_ack_cnt", 0, int'(cnt[0]), 6);
    st_valid = 1'b1;
    cyc();
    // At the limit, valid with ack: no accept possible this cycle.
    st_ack = 1'b1;
    #1;
    chk("max_va_rdy", 0, int'(st_rdy[0]), 0);
    chk("max_va_cnt", 1, int'(cnt[1]), 7);
    cyc();
    st_ack = 1'b0;
    cyc();
    st_valid = 1'b0;
    st_ack   = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    idle_in();
    #1 chk("pre_fence_cnt", 0, int'(cnt[0]), 3);
    cyc();

    // FENCE with 3 outstanding, acks at 2/4/6.
    for (int c = 0; c < 12; c++) begin
      f_valid  = (c == 0);
      f_kind   = 2'd0;
      st_valid = (c < 8);
      st_ack   = (c == 2 || c == 4 || c == 6);
      dc_ack   = (c == 9);
      #1;
      if (c < 8) chk("fence_st_rdy", 0, int'(st_rdy[0]), 0);
      chk("fence_done0", 0, int'(done[0]), (c == 8) ? 1 : 0);
      chk("fence_ic0",   0, int'(ic[0]), 0);
      chk("fence_tlb0",  0, int'(tlb[0]), 0);
      chk("fence_dc1",   1, int'(dc[1]), (c == 8 || c == 9) ? 1 : 0);
      chk("fence_done1", 1, int'(done[1]), (c == 10) ? 1 : 0);
      cyc();
    end
    idle_in();

    // FENCE.I with nothing outstanding.
    for (int c = 0; c < 8; c++) begin
      f_valid = (c == 0);
      f_kind  = 2'd1;
      dc_ack  = (c == 5);
      #1;
      chk("fi_done0", 0, int'(done[0]), (c == 2) ? 1 : 0);
      chk("fi_ic0",   0, int'(ic[0]), (c == 2) ? 1 : 0);
      chk("fi_dc1",   1, int'(dc[1]), (c >= 2 && c <= 5) ? 1 : 0);
      chk("fi_done1", 1, int'(done[1]), (c == 6) ? 1 : 0);
      chk("fi_ic1",   1, int'(ic[1]), (c == 6) ? 1 : 0);
      chk("fi_tlb1",  1, int'(tlb[1]), 0);
      cyc();
    end
    idle_in();

    // Reserved kind behaves as a plain FENCE.
    for (int c = 0; c < 6; c++) begin
      f_valid = (c == 0);
      f_kind  = 2'd3;
      dc_ack  = (c == 3);
      #1;
      chk("rsvd_done0", 0, int'(done[0]), (c == 2) ? 1 : 0);
      chk("rsvd_ic0",   0, int'(ic[0]), 0);
      chk("rsvd_tlb0",  0, int'(tlb[0]), 0);
      chk("rsvd_done1", 1, int'(done[1]), (c == 4) ? 1 : 0);
      cyc();
    end
    idle_in();

    // SFENCE.VMA with 2 outstanding, aborted by flush in DRAIN.
    st_valid = 1'b1;
    cyc();
    cyc();
    idle_in();
    for (int c = 0; c < 8; c++) begin
      f_valid = (c == 0);
      f_kind  = 2'd2;
      flush   = (c == 2);
      st_ack  = (c == 5 || c == 6);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("sf_f_rdy", i, int'(f_rdy[i]), (c == 0 || c >= 3) ? 1 : 0);
        chk("sf_done",  i, int'(done[i]), 0);
        chk("sf_tlb",   i, int'(tlb[i]), 0);
      end
      cyc();
    end
    idle_in();
    #1;
    chk("sf_cnt", 0, int'(cnt[0]), 0);
    chk("sf_nsp", 1, int'(nsp[1]), 1);
    cyc();

    // Accept+ack at zero is neutral; a bare ack at zero sets the sticky error.
    st_valid = 1'b1;
    st_ack   = 1'b1;
    cyc();
    idle_in();
    #1;
    chk("va0_cnt", 0, int'(cnt[0]), 0);
    chk("va0_err", 0, int'(err[0]), 0);
    st_ack = 1'b1;
    cyc();
    st_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("err_sticky", 0, int'(err[0]), 1);
      chk("err_cnt",    1, int'(cnt[1]), 0);
      cyc();
    end

    // Async reset while a fence is draining.
    st_valid = 1'b1;
    cyc();
    st_valid = 1'b0;
    f_valid  = 1'b1;
    f_kind   = 2'd2;
    cyc();
    f_valid = 1'b0;
    #1 chk("pre_rst_f_rdy", 0, int'(f_rdy[0]), 0);
    cyc();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("midrst");
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_done", 0, int'(done[0]), 0);
      chk("post_rst_tlb",  1, int'(tlb[1]), 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
